pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl_pkg.sv | 30 +++
 rtl/pipe_stall_ctrl_if.sv | 36 +++
 rtl/pipe_stall_ctrl_hazard_detect.sv | 17 +
 rtl/pipe_stall_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding, stall-counter width and
// the bundle of pipeline control strobes produced by the stall controller.
package pipe_stall_ctrl_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MEM_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        MEM_WAIT = ST_MEM_WAIT,
        MEM_DONE = ST_MEM_DONE
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_stall;
        logic memwb_stall;
    } ctrl_t;

    // Control word for a pipeline that simply advances.
    localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline <-> stall controller signal bundle. The master side is the
// datapath (hazard sources, memory handshake); the slave side is the controller.
interface pipe_stall_ctrl_if;
    import pipe_stall_ctrl_pkg::*;

    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_Rt_i;
    logic [4:0]       IFID_Rs_i;
    logic [4:0]       IFID_Rt_i;
    logic             Branch_i;
    logic             MemReq_i;
    logic             MemAck_i;
    logic             MemStart_o;
    logic             PCWrite_o;
    logic             IFID_stall_o;
    logic             IFID_flush_o;
    logic             IDEX_bubble_o;
    logic             EXMEM_stall_o;
    logic             MEMWB_stall_o;
    logic [CNT_W-1:0] StallCnt_o;

    modport master (
        output IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, Branch_i,
               MemReq_i, MemAck_i,
        input  MemStart_o, PCWrite_o, IFID_stall_o, IFID_flush_o,
               IDEX_bubble_o, EXMEM_stall_o, MEMWB_stall_o, StallCnt_o
    );

    modport slave (
        input  IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, Branch_i,
               MemReq_i, MemAck_i,
        output MemStart_o, PCWrite_o, IFID_stall_o, IFID_flush_o,
               IDEX_bubble_o, EXMEM_stall_o, MEMWB_stall_o, StallCnt_o
    );

endinterface

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard compare: the instruction in ID reads a register that the
// load in EX has not yet produced. Register $zero never creates a hazard.
module hazard_detect (
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       load_use
);

    // Purely combinational compare; result is used in the same cycle.
    always_comb begin
        load_use = idex_mem_read && (idex_rt != 5'd0) &&
                   ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller. A small FSM sequences multi-cycle data
// memory accesses; memory stalls freeze the whole pipe, load-use hazards insert
// a bubble, taken branches flush IF/ID. All control strobes are combinational.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
(
    input logic              clk_i,
    input logic              rst_n_i,
    pipe_stall_ctrl_if.slave bus
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             mem_stall;
    logic             mem_start;
    logic             load_use;
    ctrl_t            ctrl;

    hazard_detect u_hazard_detect (
        .idex_mem_read (bus.IDEX_MemRead_i),
        .idex_rt       (bus.IDEX_Rt_i),
        .ifid_rs       (bus.IFID_Rs_i),
        .ifid_rt       (bus.IFID_Rt_i),
        .load_use      (load_use)
    );

    // Memory-access FSM: next state, launch pulse and memory-stall condition.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
        state_d   = state_q;
        mem_stall = 1'b0;
        mem_start = 1'b0;
        case (state_q)
            IDLE: begin
                // An ack seen here is not for this access; only MEM_WAIT consumes it.
                if (bus.MemReq_i) begin
                    state_d   = MEM_WAIT;
                    mem_start = 1'b1;
                    mem_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.MemAck_i) begin
                    state_d = MEM_DONE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            // The completed instruction is still in EX/MEM, so MemReq_i is ignored.
            MEM_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State register; reset abandons any outstanding access.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating count of memory-stall cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if (mem_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Pipeline control, priority memstall > load-use > branch.
    always_comb begin
        ctrl = CTRL_RUN;
        if (mem_stall) begin
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_stall  = 1'b1;
            ctrl.exmem_stall = 1'b1;
            ctrl.memwb_stall = 1'b1;
        end else if (load_use) begin
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_bubble = 1'b1;
        end else if (bus.Branch_i) begin
            ctrl.ifid_flush  = 1'b1;
        end
    end

    assign bus.MemStart_o    = mem_start;
    assign bus.PCWrite_o     = ctrl.pc_write;
    assign bus.IFID_stall_o  = ctrl.ifid_stall;
    assign bus.IFID_flush_o  = ctrl.ifid_flush;
    assign bus.IDEX_bubble_o = ctrl.idex_bubble;
    assign bus.EXMEM_stall_o = ctrl.exmem_stall;
    assign bus.MEMWB_stall_o = ctrl.memwb_stall;
    assign bus.StallCnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a
// behavioural model of the stall rules.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: is an access waiting for its ack, is this the
    // completion cycle, and how many stall cycles have been counted.
    bit m_waiting;
    bit m_completing;
    int m_cnt;

    // Control word order: {MemStart, PCWrite, IFID_stall, IFID_flush,
    //                      IDEX_bubble, EXMEM_stall, MEMWB_stall}
    localparam logic [6:0] C_RUN    = 7'b0100000;
    localparam logic [6:0] C_LAUNCH = 7'b1010011;
    localparam logic [6:0] C_FREEZE = 7'b0010011;
    localparam logic [6:0] C_BUBBLE = 7'b0010100;
    localparam logic [6:0] C_FLUSH  = 7'b0101000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_ctrl();
        return {bus.MemStart_o, bus.PCWrite_o, bus.IFID_stall_o, bus.IFID_flush_o,
                bus.IDEX_bubble_o, bus.EXMEM_stall_o, bus.MEMWB_stall_o};
    endfunction

    function automatic bit model_memstall();
        bit idle = !m_waiting && !m_completing;
        return (idle && bus.MemReq_i) || (m_waiting && !bus.MemAck_i);
    endfunction

    function automatic logic [6:0] model_ctrl();
        bit idle = !m_waiting && !m_completing;
        bit lu   = bus.IDEX_MemRead_i && (bus.IDEX_Rt_i != 0) &&
                   (bus.IDEX_Rt_i == bus.IFID_Rs_i || bus.IDEX_Rt_i == bus.IFID_Rt_i);
        logic [6:0] c;
        if (model_memstall())  c = C_FREEZE;
        else if (lu)           c = C_BUBBLE;
        else if (bus.Branch_i) c = C_FLUSH;
        else                   c = C_RUN;
        c[6] = idle && bus.MemReq_i;
        return c;
    endfunction

    task automatic model_reset();
        m_waiting    = 1'b0;
        m_completing = 1'b0;
        m_cnt        = 0;
    endtask

    task automatic set_inputs(input bit req, input bit ack, input bit mr,
                              input int idrt, input int rs, input int rt, input bit br);
        bus.MemReq_i       = req;
        bus.MemAck_i       = ack;
        bus.IDEX_MemRead_i = mr;
        bus.IDEX_Rt_i      = 5'(idrt);
        bus.IFID_Rs_i      = 5'(rs);
        bus.IFID_Rt_i      = 5'(rt);
        bus.Branch_i       = br;
    endtask

    task automatic set_reset(input bit v);
        rst_n = v;
        if (!v) model_reset();
    endtask

    // Called just after a falling edge with inputs already applied: compare
    // against the model, advance the model over the rising edge, return at
    // the next falling edge.
    task automatic step();
        bit stall;
        #1;
        check("ctrl", 32'(dut_ctrl()), 32'(model_ctrl()));
        check("stall_cnt", 32'(bus.StallCnt_o), 32'(m_cnt));
        stall = model_memstall();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (stall && m_cnt < 65535) m_cnt++;
            if (m_completing) begin
                m_completing = 1'b0;
            end else if (m_waiting) begin
                if (bus.MemAck_i) begin
                    m_waiting    = 1'b0;
                    m_completing = 1'b1;
                end
            end else if (bus.MemReq_i) begin
                m_waiting = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        set_reset(1'b0);
        step();
        set_reset(1'b1);
    endtask

    int memwb_cycles;
    int starts;

    initial begin
        model_reset();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset with inputs idle: run word, zero count.
        set_reset(1'b0);
        #1;
        check("reset_ctrl", 32'(dut_ctrl()), 32'(C_RUN));
        check("reset_cnt", 32'(bus.StallCnt_o), 32'd0);
        step();
        set_reset(1'b1);

        // Load-use on Rs.
        set_inputs(0, 0, 1, 5, 5, 9, 0);
        #1;
        check("load_use", 32'(dut_ctrl()), 32'(C_BUBBLE));
        step();

        // $zero is never a hazard.
        set_inputs(0, 0, 1, 0, 0, 0, 0);
        #1;
        check("zero_exempt", 32'(dut_ctrl()), 32'(C_RUN));
        step();

        // Taken branch alone, then branch losing to load-use (match on Rt).
        set_inputs(0, 0, 0, 3, 3, 3, 1);
        #1;
        check("branch", 32'(dut_ctrl()), 32'(C_FLUSH));
        step();
        set_inputs(0, 0, 1, 3, 1, 3, 1);
        #1;
        check("lu_over_branch", 32'(dut_ctrl()), 32'(C_BUBBLE));
        step();

        // Miss with three unacknowledged wait cycles: the launch cycle plus
        // three waits freeze the pipe, then the ack releases it.
        do_reset();
        memwb_cycles = 0;
        starts       = 0;
        for (int i = 0; i < 5; i++) begin
            set_inputs(1, (i == 4), 0, 0, 0, 0, 0);
            #1;
            memwb_cycles += int'(bus.MEMWB_stall_o);
            starts       += int'(bus.MemStart_o);
            step();
        end
        check("miss_start_pulses", 32'(starts), 32'd1);
        check("miss_memwb_cycles", 32'(memwb_cycles), 32'd4);
        check("miss_cnt", 32'(bus.StallCnt_o), 32'd4);
        set_inputs(1, 0, 0, 0, 0, 0, 0);
        #1;
        check("mem_done_ignores_req", 32'(dut_ctrl()), 32'(C_RUN));
        step();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        step();

        // Memstall, load-use and branch together: freeze only.
        set_inputs(1, 0, 1, 7, 7, 0, 1);
        #1;
        check("all_events", 32'(dut_ctrl()), 32'(C_LAUNCH));
        step();
        set_inputs(0, 1, 0, 0, 0, 0, 0);
        step();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        step();

        // Ack arriving with the request in IDLE is not consumed there.
        set_inputs(1, 1, 0, 0, 0, 0, 0);
        step();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("early_ack_ignored", 32'(dut_ctrl()), 32'(C_FREEZE));
        step();
        set_inputs(0, 1, 0, 0, 0, 0, 0);
        step();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        step();

        // Reset in the middle of a wait abandons the access.
        set_inputs(1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        set_reset(1'b0);
        #1;
        check("rst_wait_cnt", 32'(bus.StallCnt_o), 32'd0);
        check("rst_wait_ctrl", 32'(dut_ctrl()), 32'(C_RUN));
        step();
        set_reset(1'b1);
        starts = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            starts += int'(bus.MemStart_o);
            step();
        end
        check("no_restart", 32'(starts), 32'd0);
        set_inputs(1, 0, 0, 0, 0, 0, 0);
        #1;
        check("fresh_start", 32'(bus.MemStart_o), 32'd1);
        step();

        // Saturation: a never-acknowledged access counts up to the limit.
        do_reset();
        set_inputs(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65534; i++) step();
        check("sat_preload", 32'(bus.StallCnt_o), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) step();
        check("sat_hold", 32'(bus.StallCnt_o), 32'h0000_FFFF);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_inputs($urandom_range(1, 0), ($urandom_range(2, 0) == 0), $urandom_range(1, 0),
                       $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                       $urandom_range(1, 0));
            set_reset($urandom_range(63, 0) != 0);
            step();
        end
        set_reset(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
